// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: round-robin between primary writeback (A) and
// multi-cycle writeback (B), with a two-beat lock for B paired writes.
module wb_port_arbiter #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          stall,
  input  logic          a_valid,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_data,
  output logic          a_ready,
  input  logic          b_valid,
  input  logic          b_pair,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_data,
  output logic          b_ready,
  output logic          mux_sel,
  output logic          rf_we,
  output logic [AW-1:0] rf_waddr,
  output logic [DW-1:0] rf_wdata,
  output logic          locked
);

  typedef enum logic [0:0] {StArb, StLock} state_e;

  state_e state_q, state_d;
  // last_b_q: 1 when B won the most recent grant; resets to B so A wins the first tie.
  logic   last_b_q, last_b_d;

  always_comb begin
    a_ready  = 1'b0;
    b_ready  = 1'b0;
    state_d  = state_q;
    last_b_d = last_b_q;
    if (!reset && !stall) begin
      case (state_q)
        StArb: begin
          if (a_valid && b_valid) begin
            a_ready = last_b_q;
            b_ready = !last_b_q;
          end else begin
            a_ready = a_valid;
            b_ready = b_valid;
          end
          if (b_ready && b_pair) state_d = StLock;
        end
        StLock: begin
          // Second beat or abandonment; either way the lock ends this cycle.
          b_ready = b_valid;
          state_d = StArb;
        end
        default: state_d = StArb;
      endcase
      if (a_ready) begin
        last_b_d = 1'b0;
      end else if (b_ready) begin
        last_b_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StArb;
      last_b_q <= 1'b1;
      mux_sel  <= 1'b0;
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      state_q  <= state_d;
      last_b_q <= last_b_d;
      if (a_ready) begin
        mux_sel  <= 1'b0;
        rf_waddr <= a_addr;
        rf_wdata <= a_data;
        rf_we    <= (a_addr != '0);
      end else if (b_ready) begin
        mux_sel  <= 1'b1;
        rf_waddr <= b_addr;
        rf_wdata <= b_data;
        rf_we    <= (b_addr != '0);
      end else begin
        rf_we    <= 1'b0;
      end
    end
  end

  assign locked = (state_q == StLock);

endmodule
